i2c_slave_regfile: RTL and testbench

- I2C target (responder) holding a 2**PTR_W x 8-bit register file.
- It is the far end of the bus driven by the Wishbone-to-I2C master bridge: it answers that master's address, write and read transactions on sda/scl.
- It is used as the on-chip bus partner in top-level simulation and as a reusable register-mapped peripheral.
- A local read port and a write strobe expose register contents and updates to surrounding logic.

---
 rtl/i2c_slave_regfile_if.sv | 35 +++
 rtl/i2c_slave_regfile.sv | 190 +++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_regfile_if.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave_regfile_if
// Brief    : Local register-access bus of the I2C target register file.
// Revision : 1.0
// ============================================================================
interface i2c_slave_regfile_if #(
    parameter int PTR_W = 4
);
    logic [PTR_W-1:0] loc_adr_i;
    logic [7:0]       loc_dat_o;
    logic             wr_stb_o;
    logic [PTR_W-1:0] wr_adr_o;
    logic [7:0]       wr_dat_o;
    logic             busy_o;

    modport slave (
        input  loc_adr_i,
        output loc_dat_o,
        output wr_stb_o,
        output wr_adr_o,
        output wr_dat_o,
        output busy_o
    );

    modport master (
        output loc_adr_i,
        input  loc_dat_o,
        input  wr_stb_o,
        input  wr_adr_o,
        input  wr_dat_o,
        input  busy_o
    );
endinterface
`default_nettype wire

// File: rtl/i2c_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave_regfile
// Brief    : I2C target with a 2**PTR_W x 8 register file and local access.
// Revision : 1.0
// ============================================================================
module i2c_slave_regfile #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         PTR_W    = 4
) (
    input  wire logic      clk_i,
    input  wire logic      rst_i,
    input  wire logic      scl,
    inout  wire            sda,
    i2c_slave_regfile_if.slave bus
);
    localparam int DEPTH = 1 << PTR_W;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_ADDR     = 4'd1,
        S_ADDR_ACK = 4'd2,
        S_IGNORE   = 4'd3,
        S_WR_PTR   = 4'd4,
        S_PTR_ACK  = 4'd5,
        S_WR_DATA  = 4'd6,
        S_WR_ACK   = 4'd7,
        S_RD_DATA  = 4'd8,
        S_RD_ACK   = 4'd9
    } state_t;

    logic r_scl_s1, r_scl_s2, r_scl_d;
    logic r_sda_s1, r_sda_s2, r_sda_d;

    state_t           r_state;
    logic [3:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic             r_rw;
    logic             r_mack;
    logic [PTR_W-1:0] r_ptr;
    logic             r_sda_oe;
    logic             r_busy;
    logic             r_wr_stb;
    logic [PTR_W-1:0] r_wr_adr;
    logic [7:0]       r_wr_dat;
    logic [7:0]       r_regs [DEPTH];

    logic             w_scl_rise, w_scl_fall, w_start, w_stop, w_byte_done;
    logic [7:0]       w_shift_in;
    logic [PTR_W-1:0] w_ptr_nxt;

    // Synchronizers reset to the idle (released) bus level so reset never fakes an edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            {r_scl_s1, r_scl_s2, r_scl_d} <= 3'b111;
            {r_sda_s1, r_sda_s2, r_sda_d} <= 3'b111;
        end else begin
            {r_scl_s1, r_scl_s2, r_scl_d} <= {scl, r_scl_s1, r_scl_s2};
            {r_sda_s1, r_sda_s2, r_sda_d} <= {sda, r_sda_s1, r_sda_s2};
        end
    end

    assign w_scl_rise  =  r_scl_s2 & ~r_scl_d;
    assign w_scl_fall  = ~r_scl_s2 &  r_scl_d;
    assign w_start     =  r_scl_s2 &  r_scl_d & r_sda_d & ~r_sda_s2;
    assign w_stop      =  r_scl_s2 &  r_scl_d & ~r_sda_d & r_sda_s2;
    assign w_byte_done =  w_scl_fall & (r_bit_cnt == 4'd8);
    assign w_shift_in  = {r_shift[6:0], r_sda_s2};
    assign w_ptr_nxt   =  r_ptr + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_rw      <= 1'b0;
            r_mack    <= 1'b1;
            r_ptr     <= '0;
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_wr_stb  <= 1'b0;
            r_wr_adr  <= '0;
            r_wr_dat  <= '0;
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
        end else begin
            r_wr_stb <= 1'b0;
            if (w_start) begin
                r_state   <= S_ADDR;
                r_bit_cnt <= '0;
                r_sda_oe  <= 1'b0;
            end else if (w_stop) begin
                r_state   <= S_IDLE;
                r_bit_cnt <= '0;
                r_sda_oe  <= 1'b0;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR, S_WR_PTR, S_WR_DATA: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_shift_in;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_byte_done) begin
                            r_bit_cnt <= '0;
                            if (r_state == S_ADDR) begin
                                if (r_shift[7:1] == DEV_ADDR) begin
                                    r_state  <= S_ADDR_ACK;
                                    r_rw     <= r_shift[0];
                                    r_sda_oe <= 1'b1;
                                    r_busy   <= 1'b1;
                                end else begin
                                    r_state <= S_IGNORE;
                                end
                            end else if (r_state == S_WR_PTR) begin
                                r_state  <= S_PTR_ACK;
                                r_ptr    <= r_shift[PTR_W-1:0];
                                r_sda_oe <= 1'b1;
                            end else begin
                                r_state       <= S_WR_ACK;
                                r_regs[r_ptr] <= r_shift;
                                r_wr_stb      <= 1'b1;
                                r_wr_adr      <= r_ptr;
                                r_wr_dat      <= r_shift;
                                r_ptr         <= w_ptr_nxt;
                                r_sda_oe      <= 1'b1;
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        if (w_scl_fall) begin
                            r_bit_cnt <= '0;
                            if (r_rw) begin
                                r_state  <= S_RD_DATA;
                                r_shift  <= r_regs[r_ptr];
                                r_sda_oe <= ~r_regs[r_ptr][7];
                            end else begin
                                r_state  <= S_WR_PTR;
                                r_sda_oe <= 1'b0;
                            end
                        end
                    end
                    S_PTR_ACK, S_WR_ACK: begin
                        if (w_scl_fall) begin
                            r_state   <= S_WR_DATA;
                            r_bit_cnt <= '0;
                            r_sda_oe  <= 1'b0;
                        end
                    end
                    S_RD_DATA: begin
                        if (w_scl_rise) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_byte_done) begin
                            r_state   <= S_RD_ACK;
                            r_bit_cnt <= '0;
                            r_sda_oe  <= 1'b0;
                        end else if (w_scl_fall) begin
                            r_shift  <= {r_shift[6:0], 1'b0};
                            r_sda_oe <= ~r_shift[6];
                        end
                    end
                    S_RD_ACK: begin
                        if (w_scl_rise) begin
                            r_mack <= r_sda_s2;
                        end else if (w_scl_fall) begin
                            r_bit_cnt <= '0;
                            if (!r_mack) begin
                                r_state  <= S_RD_DATA;
                                r_ptr    <= w_ptr_nxt;
                                r_shift  <= r_regs[w_ptr_nxt];
                                r_sda_oe <= ~r_regs[w_ptr_nxt][7];
                            end else begin
                                r_state <= S_IGNORE;
                            end
                        end
                    end
                    default: begin
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda          = r_sda_oe ? 1'b0 : 1'bz;
    assign bus.loc_dat_o = r_regs[bus.loc_adr_i];
    assign bus.wr_stb_o  = r_wr_stb;
    assign bus.wr_adr_o  = r_wr_adr;
    assign bus.wr_dat_o  = r_wr_dat;
    assign bus.busy_o    = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_slave_regfile
// Brief    : Directed I2C master bench with write/read scoreboards for the target.
// Revision : 1.0
// ============================================================================
module tb_i2c_slave_regfile;
    localparam int Q = 10;

    logic clk_i     = 1'b0;
    logic rst_i     = 1'b1;
    logic m_scl     = 1'b1;
    logic m_sda_low = 1'b0;
    wire  sda;

    assign sda = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk_i = ~clk_i;

    i2c_slave_regfile_if #(.PTR_W(4)) bif ();

    i2c_slave_regfile #(.DEV_ADDR(7'h50), .PTR_W(4)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .scl   (m_scl),
        .sda   (sda),
        .bus   (bif)
    );

    typedef struct packed {
        logic [3:0] adr;
        logic [7:0] dat;
    } stb_t;

    int         checks = 0;
    int         errors = 0;
    stb_t       stb_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] model [16];
    stb_t       mon_e;
    bit         watch_low = 1'b0;
    int         low_cnt   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Every write strobe must match the oldest pending expected commit.
    always @(negedge clk_i) begin
        if (bif.wr_stb_o === 1'b1) begin
            chk("wr_stb_expected", {31'd0, stb_q.size() > 0}, 32'd1);
            if (stb_q.size() > 0) begin
                mon_e = stb_q.pop_front();
                chk("wr_adr", {28'd0, bif.wr_adr_o}, {28'd0, mon_e.adr});
                chk("wr_dat", {24'd0, bif.wr_dat_o}, {24'd0, mon_e.dat});
            end
        end
        if (watch_low && sda === 1'b0 && !m_sda_low) low_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic start_c();
        if (!m_scl) begin
            m_sda_low = 1'b0; cyc(Q);
            m_scl = 1'b1;     cyc(2*Q);
        end
        m_sda_low = 1'b1; cyc(2*Q);
        m_scl = 1'b0;     cyc(Q);
    endtask

    task automatic stop_c();
        m_sda_low = 1'b1; cyc(Q);
        m_scl = 1'b1;     cyc(2*Q);
        m_sda_low = 1'b0; cyc(2*Q);
    endtask

    task automatic put_bit(input logic b);
        m_sda_low = ~b; cyc(Q);
        m_scl = 1'b1;   cyc(2*Q);
        m_scl = 1'b0;   cyc(Q);
    endtask

    task automatic get_bit(output logic b);
        m_sda_low = 1'b0; cyc(Q);
        m_scl = 1'b1;     cyc(Q);
        b = sda;          cyc(Q);
        m_scl = 1'b0;     cyc(Q);
    endtask

    task automatic wr_byte(input string tag, input logic [7:0] d, input logic exp_ack);
        logic a;
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(a);
        chk(tag, {31'd0, a}, {31'd0, exp_ack});
    endtask

    task automatic wr_data(input string tag, input logic [3:0] adr, input logic [7:0] d);
        stb_q.push_back('{adr: adr, dat: d});
        model[adr] = d;
        wr_byte(tag, d, 1'b0);
    endtask

    task automatic rd_byte(input string tag, input logic nack);
        logic [7:0] d;
        logic [7:0] e;
        for (int i = 7; i >= 0; i--) get_bit(d[i]);
        put_bit(nack);
        e = rd_q.pop_front();
        chk(tag, {24'd0, d}, {24'd0, e});
    endtask

    task automatic loc_chk(input string tag);
        for (int i = 0; i < 16; i++) begin
            bif.loc_adr_i = i[3:0];
            #1;
            chk(tag, {24'd0, bif.loc_dat_o}, {24'd0, model[i]});
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        bif.loc_adr_i = 4'd0;
        cyc(5);
        rst_i = 1'b0;
        cyc(2);

        chk("rst_busy",   {31'd0, bif.busy_o},   32'd0);
        chk("rst_wr_stb", {31'd0, bif.wr_stb_o}, 32'd0);
        chk("rst_wr_adr", {28'd0, bif.wr_adr_o}, 32'd0);
        chk("rst_wr_dat", {24'd0, bif.wr_dat_o}, 32'd0);
        chk("rst_sda",    {31'd0, sda},          32'd1);
        loc_chk("rst_loc");

        // Two-byte write starting at register 3
        start_c();
        wr_byte("t1_addr_ack", 8'hA0, 1'b0);
        chk("t1_busy_hi", {31'd0, bif.busy_o}, 32'd1);
        wr_byte("t1_ptr_ack", 8'h03, 1'b0);
        wr_data("t1_d0_ack", 4'd3, 8'hA5);
        wr_data("t1_d1_ack", 4'd4, 8'h5A);
        stop_c();
        chk("t1_busy_lo", {31'd0, bif.busy_o}, 32'd0);
        bif.loc_adr_i = 4'd4; #1;
        chk("t1_loc4", {24'd0, bif.loc_dat_o}, 32'h5A);
        chk("t1_stb_done", stb_q.size(), 32'd0);

        // Random read: pointer write, repeated START, two-byte read
        start_c();
        wr_byte("t2_addr_ack", 8'hA0, 1'b0);
        wr_byte("t2_ptr_ack",  8'h03, 1'b0);
        start_c();
        wr_byte("t2_raddr_ack", 8'hA1, 1'b0);
        rd_q.push_back(model[3]);
        rd_q.push_back(model[4]);
        rd_byte("t2_rd0", 1'b0);
        rd_byte("t2_rd1", 1'b1);
        chk("t2_released", {31'd0, sda}, 32'd1);
        chk("t2_busy_hi",  {31'd0, bif.busy_o}, 32'd1);
        stop_c();
        chk("t2_busy_lo",  {31'd0, bif.busy_o}, 32'd0);

        // Foreign address: bus never pulled low by the target
        watch_low = 1'b1;
        start_c();
        wr_byte("t3_addr_nack", 8'hA2, 1'b1);
        wr_byte("t3_b0_nack",   8'h00, 1'b1);
        wr_byte("t3_b1_nack",   8'hFF, 1'b1);
        stop_c();
        watch_low = 1'b0;
        chk("t3_no_drive", low_cnt, 32'd0);
        chk("t3_busy", {31'd0, bif.busy_o}, 32'd0);
        loc_chk("t3_loc");

        // Pointer wrap from 15 to 0
        start_c();
        wr_byte("t4_addr_ack", 8'hA0, 1'b0);
        wr_byte("t4_ptr_ack",  8'h0F, 1'b0);
        wr_data("t4_d0_ack", 4'd15, 8'h11);
        wr_data("t4_d1_ack", 4'd0,  8'h22);
        stop_c();
        loc_chk("t4_loc");

        // STOP after 5 data bits: nothing committed, pointer stays at 4
        start_c();
        wr_byte("t5_addr_ack", 8'hA0, 1'b0);
        wr_byte("t5_ptr_ack",  8'h04, 1'b0);
        for (int i = 0; i < 5; i++) put_bit(1'b1);
        stop_c();
        start_c();
        wr_byte("t5_raddr_ack", 8'hA1, 1'b0);
        rd_q.push_back(model[4]);
        rd_byte("t5_rd", 1'b1);
        stop_c();
        chk("t5_stb_done", stb_q.size(), 32'd0);
        loc_chk("t5_loc");

        // Reset while the address ACK is on the bus
        start_c();
        for (int i = 7; i >= 0; i--) put_bit(1'(8'hA0 >> i));
        m_sda_low = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 2*Q && !seen; i++) begin
            if (sda === 1'b0) seen = 1'b1;
            else cyc(1);
        end
        chk("t6_ack_driven", {31'd0, seen}, 32'd1);
        chk("t6_busy_hi", {31'd0, bif.busy_o}, 32'd1);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("t6_sda_released", {31'd0, sda}, 32'd1);
        cyc(2);
        rst_i = 1'b0;
        m_scl = 1'b1;
        cyc(4);
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        chk("t6_busy_lo", {31'd0, bif.busy_o},   32'd0);
        chk("t6_wr_stb",  {31'd0, bif.wr_stb_o}, 32'd0);
        loc_chk("t6_loc");

        chk("final_stb_q", stb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
